// File: rtl/button_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Brief    : Synchronizes, debounces and auto-repeats one raw push button.
// Revision : 1.0
// ============================================================================
// `release` is a reserved word, so the release event port is release_pulse.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES      = 240000,
  parameter bit REPEAT_EN            = 1'b1,
  parameter int REPEAT_DELAY_CYCLES  = 12000000,
  parameter int REPEAT_PERIOD_CYCLES = 2400000,
  parameter bit ACTIVE_LOW           = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic pressed,
  output logic press,
  output logic release_pulse,
  output logic tick,
  output logic repeating
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                        REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int RW   = $clog2(RMAX) + 1;

  localparam logic [DW-1:0] DEB_TERM = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_TERM = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] PER_TERM = RW'(REPEAT_PERIOD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RELEASED  = 2'd0,
    S_HELD      = 2'd1,
    S_REPEATING = 2'd2
  } state_t;

  logic          raw_p;
  logic          sync_meta;
  logic          sync_p;
  logic [DW-1:0] dcnt;
  logic          differ;
  logic          settle;
  logic          rise;
  logic          fall;
  state_t        state;
  state_t        state_nx;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_nx;
  logic          tick_nx;

  // Normalize to "1 = pressed" before synchronizing; reset value is released.
  assign raw_p = btn_in ^ ACTIVE_LOW;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_p    <= 1'b0;
    end else begin
      sync_meta <= raw_p;
      sync_p    <= sync_meta;
    end
  end

  assign differ = (sync_p != pressed);
  assign settle = differ && (dcnt == DEB_TERM);
  assign rise   = settle && sync_p;
  assign fall   = settle && !sync_p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dcnt          <= '0;
      pressed       <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press         <= rise;
      release_pulse <= fall;
      if (settle) begin
        pressed <= sync_p;
        dcnt    <= '0;
      end else if (differ) begin
        dcnt <= dcnt + 1'b1;
      end else begin
        dcnt <= '0;
      end
    end
  end

  // An expiry that lands right after a tick is held off one cycle so ticks
  // never touch, even with a period of one.
  always_comb begin
    state_nx = state;
    rcnt_nx  = rcnt;
    tick_nx  = 1'b0;
    case (state)
      S_RELEASED: begin
        if (rise) begin
          state_nx = S_HELD;
          rcnt_nx  = '0;
          tick_nx  = 1'b1;
        end
      end
      S_HELD: begin
        if (fall) begin
          state_nx = S_RELEASED;
          rcnt_nx  = '0;
        end else if (rcnt == DLY_TERM) begin
          if (REPEAT_EN && !tick) begin
            state_nx = S_REPEATING;
            rcnt_nx  = '0;
            tick_nx  = 1'b1;
          end
        end else begin
          rcnt_nx = rcnt + 1'b1;
        end
      end
      S_REPEATING: begin
        if (fall) begin
          state_nx = S_RELEASED;
          rcnt_nx  = '0;
        end else if (rcnt == PER_TERM) begin
          if (!tick) begin
            rcnt_nx = '0;
            tick_nx = 1'b1;
          end
        end else begin
          rcnt_nx = rcnt + 1'b1;
        end
      end
      default: begin
        state_nx = S_RELEASED;
        rcnt_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RELEASED;
      rcnt  <= '0;
      tick  <= 1'b0;
    end else begin
      state <= state_nx;
      rcnt  <= rcnt_nx;
      tick  <= tick_nx;
    end
  end

  assign repeating = (state == S_REPEATING);

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for button_conditioner: directed scenarios plus random bouncing,
// checked against an event-level model (sample history and press age).
module tb_button_conditioner;

  localparam int DEB  = 4;
  localparam int RDLY = 10;
  localparam int RPER = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_in = 1'b1;

  logic pressed0, press0, rel0, tick0, rep0;
  logic pressed1, press1, rel1, tick1, rep1;

  int checks = 0;
  int failures = 0;

  // model state
  bit hist[$];
  bit s1m, s2m, m_pressed, m_press, m_rel;
  bit m_held[2];
  bit m_tick[2];
  bit m_rep[2];
  int m_age[2];

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1'b1), .REPEAT_DELAY_CYCLES(RDLY),
    .REPEAT_PERIOD_CYCLES(RPER), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .pressed(pressed0),
    .press(press0), .release_pulse(rel0), .tick(tick0), .repeating(rep0)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1'b0), .REPEAT_DELAY_CYCLES(RDLY),
    .REPEAT_PERIOD_CYCLES(RPER), .ACTIVE_LOW(1'b1)
  ) dut_nr (
    .clk(clk), .reset(reset), .btn_in(btn_in), .pressed(pressed1),
    .press(press1), .release_pulse(rel1), .tick(tick1), .repeating(rep1)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    s1m = 1'b0; s2m = 1'b0; m_pressed = 1'b0; m_press = 1'b0; m_rel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_held[i] = 1'b0; m_tick[i] = 1'b0; m_rep[i] = 1'b0; m_age[i] = 0;
    end
  endtask

  // One rising edge: the level flips once the last DEB synchronized samples
  // all disagree with it; ticks follow from the age of the current press.
  task automatic model_edge();
    bit all_new, rise, fall;
    hist.push_back(s2m);
    if (hist.size() > DEB) void'(hist.pop_front());
    all_new = (hist.size() == DEB);
    foreach (hist[j]) if (hist[j] == m_pressed) all_new = 1'b0;
    rise = all_new && !m_pressed;
    fall = all_new && m_pressed;
    if (all_new) m_pressed = !m_pressed;
    m_press = rise;
    m_rel   = fall;
    for (int i = 0; i < 2; i++) begin
      m_tick[i] = 1'b0;
      if (rise) begin
        m_held[i] = 1'b1; m_age[i] = 0; m_tick[i] = 1'b1;
      end else if (fall) begin
        m_held[i] = 1'b0;
      end else if (m_held[i]) begin
        m_age[i]++;
        if (i == 0 && m_age[i] >= RDLY && (m_age[i] - RDLY) % RPER == 0)
          m_tick[i] = 1'b1;
      end
      m_rep[i] = m_held[i] && (i == 0) && (m_age[i] >= RDLY);
    end
    s2m = s1m;
    s1m = ~btn_in;
  endtask

  task automatic compare_all();
    chk("pressed", pressed0, m_pressed);
    chk("press", press0, m_press);
    chk("release", rel0, m_rel);
    chk("tick", tick0, m_tick[0]);
    chk("repeating", rep0, m_rep[0]);
    chk("nr_pressed", pressed1, m_pressed);
    chk("nr_press", press1, m_press);
    chk("nr_release", rel1, m_rel);
    chk("nr_tick", tick1, m_tick[1]);
    chk("nr_repeating", rep1, m_rep[1]);
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Drive a press and step until the press pulse; returns edges taken.
  task automatic press_and_wait(input string tag, output int n);
    btn_in = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!press0 && n < 20);
    chk_int({tag, "_latency"}, n, DEB + 2);
    chk({tag, "_tick"}, tick0, 1'b1);
  endtask

  initial begin
    int n, nr_ticks;
    logic any_high, any_rep;
    int got[$];
    int exp_off[8];
    exp_off = '{0, 10, 15, 20, 25, 30, 35, 40};

    model_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_pressed", pressed0, 1'b0);
    chk("rst_tick", tick0, 1'b0);
    step();
    step();
    #3 reset = 1'b0;
    idle(8);

    // Clean press, then hold to watch the auto-repeat cadence.
    press_and_wait("clean", n);
    chk("clean_press_pulse", press0, 1'b1);
    got.push_back(0);
    for (int off = 1; off <= 41; off++) begin
      step();
      if (tick0) got.push_back(off);
      if (off == 8) chk("no_repeat_by_8", (got.size() == 1) ? 1'b1 : 1'b0, 1'b1);
      if (off == 9) chk("rep_off9", rep0, 1'b0);
      if (off == 10) chk("rep_off10", rep0, 1'b1);
    end
    chk_int("tick_count", got.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < got.size()) chk_int("tick_offset", got[k], exp_off[k]);
    btn_in = 1'b1;
    idle(5);
    chk("rel_not_yet", rel0, 1'b0);
    step();
    chk("rel_pulse", rel0, 1'b1);
    chk("rel_no_tick", tick0, 1'b0);
    chk("rel_not_rep", rep0, 1'b0);
    idle(8);

    // Bounce shorter than the filter window.
    any_high = 1'b0;
    for (int c = 0; c < 20; c++) begin
      btn_in = ((c / 2) % 2) ? 1'b1 : 1'b0;
      step();
      any_high |= pressed0 | press0 | tick0;
    end
    btn_in = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      any_high |= pressed0 | press0 | tick0;
    end
    chk("bounce_quiet", any_high, 1'b0);

    // Release aligned with the offset-15 repeat expiry.
    press_and_wait("coll", n);
    idle(9);
    btn_in = 1'b1;
    idle(6);
    chk("coll_release", rel0, 1'b1);
    chk("coll_no_tick", tick0, 1'b0);
    chk("coll_not_rep", rep0, 1'b0);
    any_high = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      any_high |= tick0 | rep0;
    end
    chk("coll_released_quiet", any_high, 1'b0);

    // Repeat disabled: one tick per press.
    press_and_wait("nr", n);
    nr_ticks = tick1 ? 1 : 0;
    any_rep = rep1;
    for (int c = 0; c < 50; c++) begin
      step();
      if (tick1) nr_ticks++;
      any_rep |= rep1;
    end
    chk_int("nr_single_tick", nr_ticks, 1);
    chk("nr_never_rep", any_rep, 1'b0);
    btn_in = 1'b1;
    idle(10);

    // Reset in the middle of a repeating hold.
    press_and_wait("mid", n);
    idle(12);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_pressed", pressed0, 1'b0);
    chk("mid_rst_press", press0, 1'b0);
    chk("mid_rst_release", rel0, 1'b0);
    chk("mid_rst_tick", tick0, 1'b0);
    chk("mid_rst_rep", rep0, 1'b0);
    step();
    step();
    #3 reset = 1'b0;
    press_and_wait("after_rst", n);
    btn_in = 1'b1;
    idle(10);

    // Random bouncing, long holds and occasional resets.
    for (int seg = 0; seg < 200; seg++) begin
      int len;
      btn_in = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                        : int'($urandom_range(1, 6));
      if ($urandom_range(0, 49) == 0) begin
        #2 reset = 1'b1;
        model_reset();
        #2 reset = 1'b0;
      end
      idle(len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions one raw push-button input into clean, single-clock-cycle events for the display counters.
- Stages: 2-FF synchronizer, debounce filter, optional auto-repeat.
- Sits directly upstream of the 7-segment counter logic. Its tick output replaces raw button levels as the count enable, so all counting runs on clk.

Parameters:
- DEBOUNCE_CYCLES, 240000, consecutive stable synchronized samples required before the debounced level changes (10 ms at 24 MHz); must be ≥1.
- REPEAT_EN, 1, 1 enables auto-repeat ticks while held; 0 gives one tick per press.
- REPEAT_DELAY_CYCLES, 12000000, cycles from the press event to the first repeat tick (500 ms); must be ≥1.
- REPEAT_PERIOD_CYCLES, 2400000, cycles between subsequent repeat ticks (100 ms); must be ≥1.
- ACTIVE_LOW, 1, 1 means btn_in = 0 is pressed; 0 means btn_in = 1 is pressed.

Ports:
- clk  input  1  system clock (XTAL).
- reset  input  1  reset, asynchronous, active-high.
- btn_in  input  1  raw button pin; asynchronous to clk; bounces.
- pressed  output  1  debounced level; 1 while the button is held.
- press  output  1  one-cycle pulse on each debounced press.
- release  output  1  one-cycle pulse on each debounced release.
- tick  output  1  one-cycle count pulse: on the press event and on every repeat event.
- repeating  output  1  1 while in the REPEATING state.

Behaviour:
- Reset (asynchronous):
  - All outputs are 0.
  - Synchronizer flops are loaded with the released polarity.
  - Debounce and repeat counters are cleared.
  - FSM goes to RELEASED.
- Normalization: raw_p = btn_in XOR ACTIVE_LOW, passed through 2 flops to give sync_p.
- Debounce:
  - dcnt increments on every cycle where sync_p != pressed.
  - A cycle where sync_p == pressed clears dcnt; any bounce restarts the filter.
  - When sync_p != pressed and dcnt == DEBOUNCE_CYCLES-1: pressed <= sync_p and dcnt <= 0.
  - Latency: pressed changes on the (DEBOUNCE_CYCLES+2)th rising edge after btn_in settles at a new value.
  - Glitches shorter than DEBOUNCE_CYCLES sampled cycles are never seen on any output.
- Events (all registered):
  - press is 1 in exactly the first cycle pressed reads 1.
  - release is 1 in exactly the first cycle pressed reads 0.
  - press and release are never high in the same cycle.
- FSM states: RELEASED, HELD, REPEATING. rcnt is the repeat counter.
  - RELEASED: on the debounced press → HELD, rcnt <= 0, tick = 1 in the same cycle as press.
  - HELD: rcnt increments each cycle. At rcnt == REPEAT_DELAY_CYCLES-1 with REPEAT_EN=1 → tick, rcnt <= 0, → REPEATING. With REPEAT_EN=0, stay in HELD with no further ticks; rcnt saturates.
  - REPEATING: rcnt increments each cycle. At rcnt == REPEAT_PERIOD_CYCLES-1 → tick, rcnt <= 0.
  - HELD or REPEATING: debounced release → RELEASED, rcnt <= 0, no tick.
- Simultaneous events: if the debounced release and a repeat expiry fall on the same cycle, release wins; no tick is produced that cycle.
- Tick spacing: ticks are always ≥1 cycle apart; tick is never high for 2 consecutive cycles, even with REPEAT_PERIOD_CYCLES=1.
- Counter widths:
  - dcnt: $clog2(DEBOUNCE_CYCLES+1).
  - rcnt: $clog2 of the larger of REPEAT_DELAY_CYCLES and REPEAT_PERIOD_CYCLES, plus 1.
  - Counters never wrap past their terminal value.
- Reset while the button is held: outputs return to 0 immediately. After reset deasserts, a still-held button re-debounces from the released state and generates a fresh press+tick DEBOUNCE_CYCLES+2 edges later.
- Reset while a bounce or debounce is in progress: the partial count is discarded.
- No combinational path from btn_in to any output.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_PERIOD_CYCLES=5, ACTIVE_LOW=1):
- Clean press, hold 8 cycles: drive btn_in 1→0 → pressed rises on the 6th edge; press=tick=1 for that one cycle; no repeat tick within 8 cycles.
- Bounce rejection: btn_in toggles 0/1 every 2 cycles for 20 cycles, then held at 1 → pressed, press, tick stay 0 throughout.
- Auto-repeat: hold btn_in=0 for 40 cycles after pressed rises:
  - ticks at offsets 0, 10, 15, 20, 25, 30, 35 relative to the press cycle;
  - repeating=1 from offset 10.
  - Release, then 6 edges later: release=1, tick=0, repeating=0.
- Release/repeat collision: align the debounced release with offset 15 → release=1, tick=0 on that cycle; FSM in RELEASED.
- REPEAT_EN=0, hold 50 cycles → exactly one tick; repeating stays 0.
- Reset mid-hold:
  - Assert reset at offset 12 → all outputs 0 asynchronously, before the next clk edge.
  - Deassert with btn_in still 0 → press=tick=1 on the 6th edge after deassertion.
